mono_rs: RTL and testbench
==========================

# mono_rs

Single-dispatch-port, single-issue reservation station used for the BR and MEM queues. It accepts one uop per cycle from the dispatch stage over the mono dispatch handshake and holds it until both source operands are ready. Ready state comes from the rename-time ready bits or from CDB wakeups. Each cycle it issues the oldest ready entry to its functional unit.

## Interface
Parameters:
- DEPTH, 8: number of entries (power of two, ≥2).
- PRF_IDX_W, 6: physical register tag width; tag 0 is the hard-wired zero register and is always ready.
- PAYLOAD_W, 64: opaque uop payload width, carried unmodified.
- CDB_WIDTH, 2: number of CDB broadcast ports.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  backend flush, synchronous.
- ds_valid  in  1  dispatch offers a uop.
- ds_ready  out  1  RS can accept a uop.
- ds_payload  in  PAYLOAD_W  incoming uop payload.
- ds_rs1, ds_rs2  in  PRF_IDX_W each  source physical tags.
- ds_rs1_rdy, ds_rs2_rdy  in  1 each  operand ready at rename.
- cdb_valid  in  CDB_WIDTH  per-port broadcast valid.
- cdb_tag  in  CDB_WIDTH×PRF_IDX_W  per-port produced physical tag.
- iss_valid  out  1  issue request.
- iss_ready  in  1  FU accepts.
- iss_payload  out  PAYLOAD_W  issued payload.
- iss_rs1, iss_rs2  out  PRF_IDX_W each  issued source tags.
- occupancy  out  $clog2(DEPTH)+1  number of valid entries.

## Operation
- Entry state: valid, rs1/rs2 tag, rs1/rs2 ready bit, payload. Age is held in a DEPTH×DEPTH age matrix, where row i column j set means i is older than j.
- Allocation: on ds_valid && ds_ready && !flush, write the lowest-index free entry. Set the new entry older-than-none; every other valid entry becomes older than it.
- Ready bit at allocation: ds_rsN_rdy, OR tag==0, OR a match against any valid CDB port in the same cycle. The same-cycle CDB check is mandatory so that no wakeup is lost.
- Wakeup: each valid entry sets its rsN ready bit when any cdb_valid[k] && cdb_tag[k]==rsN. Tag 0 never needs a wakeup.
- Select: candidates are valid entries with both registered ready bits set. The oldest candidate, found via the age matrix, drives the iss_* outputs.
- Issue: on iss_valid && iss_ready, clear the selected entry's valid bit and its age row/column.
- ds_ready = (occupancy < DEPTH), computed from registered state only. An entry freed by issue becomes allocatable the next cycle.
- iss_payload, iss_rs1 and iss_rs2 are 0 whenever iss_valid=0.
- flush: all valid bits clear next cycle. During the flush cycle iss_valid=0, and dispatch is dropped even if ds_valid=1.

## Timing
- Reset: all entries invalid, occupancy=0, ds_ready=1, iss_valid=0, iss_* =0.
- Dispatch with both operands ready: earliest issue is the cycle after allocation (latency 1).
- CDB wakeup in cycle N: the entry can issue in cycle N+1.
- Simultaneous dispatch and issue at full occupancy: cannot happen, because ds_ready=0 while full.
- Simultaneous dispatch and issue below full: both happen. Occupancy is unchanged.
- Full at DEPTH: ds_ready=0 until the cycle after an issue.
- Empty: iss_valid=0 (except via bypass).
- No combinational path from iss_ready to ds_ready.
- Reset asserted mid-operation clears all state immediately (asynchronously).

## Configuration
- MONO_RS_ISSUE_BYPASS_EN defined:
  - Bypass fires when no stored entry is a candidate, ds_valid && ds_ready && !flush, and both incoming operands are ready (including same-cycle CDB).
  - When it fires, iss_valid=1 with the incoming payload and tags (0-cycle latency).
  - If iss_ready=1, the uop is not allocated. If iss_ready=0, it is allocated normally.
  - This adds a combinational path from ds_* to iss_*.
- MONO_RS_ISSUE_BYPASS_EN undefined: no bypass. Minimum dispatch-to-issue latency is 1 cycle, and iss_* depend only on registered state.

## Test plan
- Reset, then dispatch payload 0xA5, rs1=3/rs2=5 both ready, iss_ready=1 -> iss_valid in the next cycle with payload 0xA5 (same cycle if bypass is enabled); occupancy returns to 0.
- Dispatch A (rs1=7 not ready), then B (ready); iss_ready=1 -> B issues first. CDB tag 7 in cycle N -> A issues in N+1.
- Dispatch uop with rs2=9 not ready while the CDB broadcasts tag 9 in the same cycle -> entry stored ready, issues next cycle.
- Fill 8 entries with iss_ready=0 -> ds_ready=0 at occupancy 8. Raise iss_ready for 1 cycle -> oldest issues, ds_ready=1 the following cycle.
- Three ready entries dispatched in order X, Y, Z into non-sequential slots (after frees), iss_ready=1 -> issue order X, Y, Z.
- 4 entries valid, assert flush together with ds_valid=1 -> iss_valid=0 that cycle, occupancy=0 next cycle, flushed uop not stored.

Source files
------------

// File: rtl/mono_rs_if.sv
// Dispatch, CDB wakeup and issue handshake bundle for mono_rs.
// master is the surrounding pipeline; slave is the reservation station.
interface mono_rs_if #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned PRF_IDX_W = 6,
    parameter int unsigned PAYLOAD_W = 64,
    parameter int unsigned CDB_WIDTH = 2
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                           flush;
    logic                           ds_valid;
    logic                           ds_ready;
    logic [PAYLOAD_W-1:0]           ds_payload;
    logic [PRF_IDX_W-1:0]           ds_rs1;
    logic [PRF_IDX_W-1:0]           ds_rs2;
    logic                           ds_rs1_rdy;
    logic                           ds_rs2_rdy;
    logic [CDB_WIDTH-1:0]           cdb_valid;
    logic [CDB_WIDTH*PRF_IDX_W-1:0] cdb_tag;
    logic                           iss_valid;
    logic                           iss_ready;
    logic [PAYLOAD_W-1:0]           iss_payload;
    logic [PRF_IDX_W-1:0]           iss_rs1;
    logic [PRF_IDX_W-1:0]           iss_rs2;
    logic [CNT_W-1:0]               occupancy;

    modport master (
        output flush, ds_valid, ds_payload, ds_rs1, ds_rs2, ds_rs1_rdy, ds_rs2_rdy,
        output cdb_valid, cdb_tag, iss_ready,
        input  ds_ready, iss_valid, iss_payload, iss_rs1, iss_rs2, occupancy
    );

    modport slave (
        input  flush, ds_valid, ds_payload, ds_rs1, ds_rs2, ds_rs1_rdy, ds_rs2_rdy,
        input  cdb_valid, cdb_tag, iss_ready,
        output ds_ready, iss_valid, iss_payload, iss_rs1, iss_rs2, occupancy
    );
endinterface

// File: rtl/mono_rs.sv
// Single-port, single-issue reservation station with age-matrix oldest-ready select.
// Define MONO_RS_ISSUE_BYPASS_EN to let a ready incoming uop issue in its dispatch cycle.
module mono_rs #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned PRF_IDX_W = 6,
    parameter int unsigned PAYLOAD_W = 64,
    parameter int unsigned CDB_WIDTH = 2
) (
    input logic        clk,
    input logic        rst,
    mono_rs_if.slave   rs_if
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [DEPTH-1:0]     rdy1_q, rdy1_d;
    logic [DEPTH-1:0]     rdy2_q, rdy2_d;
    logic [PRF_IDX_W-1:0] rs1_q [DEPTH];
    logic [PRF_IDX_W-1:0] rs1_d [DEPTH];
    logic [PRF_IDX_W-1:0] rs2_q [DEPTH];
    logic [PRF_IDX_W-1:0] rs2_d [DEPTH];
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];
    logic [PAYLOAD_W-1:0] payload_d [DEPTH];
    // age_q[i][j] set means entry i is older than entry j
    logic [DEPTH-1:0]     age_q [DEPTH];
    logic [DEPTH-1:0]     age_d [DEPTH];

    logic [CNT_W-1:0]     occ;
    logic                 ds_ready;
    logic [IDX_W-1:0]     alloc_idx;
    logic [DEPTH-1:0]     cand;
    logic [DEPTH-1:0]     sel_oh;
    logic [IDX_W-1:0]     sel_idx;
    logic                 any_cand;
    logic [PAYLOAD_W-1:0] sel_payload;
    logic [PRF_IDX_W-1:0] sel_rs1;
    logic [PRF_IDX_W-1:0] sel_rs2;
    logic                 in_rdy1;
    logic                 in_rdy2;
    logic                 dispatch_ok;
    logic                 bypass;
    logic                 stored_iss;
    logic                 issue_fire;
    logic                 alloc;

    function automatic logic cdb_hit(
        input logic [PRF_IDX_W-1:0]           tag,
        input logic [CDB_WIDTH-1:0]           vld,
        input logic [CDB_WIDTH*PRF_IDX_W-1:0] tags
    );
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < CDB_WIDTH; k++) begin
            if (vld[k] && (tags[k*PRF_IDX_W +: PRF_IDX_W] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ = occ + CNT_W'(valid_q[i]);
        end
    end

    assign ds_ready = (occ < CNT_W'(DEPTH));

    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                alloc_idx = IDX_W'(i);
            end
        end
    end

    assign cand     = valid_q & rdy1_q & rdy2_q;
    assign any_cand = |cand;

    // A candidate wins unless some other candidate is older than it.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            sel_oh[i] = cand[i];
            for (int j = 0; j < DEPTH; j++) begin
                if ((j != i) && cand[j] && age_q[j][i]) begin
                    sel_oh[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        sel_idx     = '0;
        sel_payload = '0;
        sel_rs1     = '0;
        sel_rs2     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_oh[i]) begin
                sel_idx     = IDX_W'(i);
                sel_payload = sel_payload | payload_q[i];
                sel_rs1     = sel_rs1 | rs1_q[i];
                sel_rs2     = sel_rs2 | rs2_q[i];
            end
        end
    end

    assign in_rdy1 = rs_if.ds_rs1_rdy || (rs_if.ds_rs1 == '0) ||
                     cdb_hit(rs_if.ds_rs1, rs_if.cdb_valid, rs_if.cdb_tag);
    assign in_rdy2 = rs_if.ds_rs2_rdy || (rs_if.ds_rs2 == '0) ||
                     cdb_hit(rs_if.ds_rs2, rs_if.cdb_valid, rs_if.cdb_tag);

    assign dispatch_ok = rs_if.ds_valid && ds_ready && !rs_if.flush;
    assign stored_iss  = any_cand && !rs_if.flush;

`ifdef MONO_RS_ISSUE_BYPASS_EN
    assign bypass = !any_cand && dispatch_ok && in_rdy1 && in_rdy2;
`else
    assign bypass = 1'b0;
`endif

    assign issue_fire = stored_iss && rs_if.iss_ready;
    // A bypassed uop that the FU takes immediately never occupies an entry.
    assign alloc      = dispatch_ok && !(bypass && rs_if.iss_ready);

    assign rs_if.ds_ready    = ds_ready;
    assign rs_if.occupancy   = occ;
    assign rs_if.iss_valid   = stored_iss || bypass;
    assign rs_if.iss_payload = stored_iss ? sel_payload :
                               (bypass ? rs_if.ds_payload : '0);
    assign rs_if.iss_rs1     = stored_iss ? sel_rs1 : (bypass ? rs_if.ds_rs1 : '0);
    assign rs_if.iss_rs2     = stored_iss ? sel_rs2 : (bypass ? rs_if.ds_rs2 : '0);

    always_comb begin
        valid_d   = valid_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        payload_d = payload_q;
        age_d     = age_q;
        for (int i = 0; i < DEPTH; i++) begin
            rdy1_d[i] = rdy1_q[i] | cdb_hit(rs1_q[i], rs_if.cdb_valid, rs_if.cdb_tag);
            rdy2_d[i] = rdy2_q[i] | cdb_hit(rs2_q[i], rs_if.cdb_valid, rs_if.cdb_tag);
        end

        if (issue_fire) begin
            valid_d[sel_idx] = 1'b0;
            age_d[sel_idx]   = '0;
            for (int j = 0; j < DEPTH; j++) begin
                age_d[j][sel_idx] = 1'b0;
            end
        end

        if (alloc) begin
            for (int j = 0; j < DEPTH; j++) begin
                age_d[j][alloc_idx] = valid_d[j];
            end
            age_d[alloc_idx]     = '0;
            valid_d[alloc_idx]   = 1'b1;
            rs1_d[alloc_idx]     = rs_if.ds_rs1;
            rs2_d[alloc_idx]     = rs_if.ds_rs2;
            rdy1_d[alloc_idx]    = in_rdy1;
            rdy2_d[alloc_idx]    = in_rdy2;
            payload_d[alloc_idx] = rs_if.ds_payload;
        end

        if (rs_if.flush) begin
            valid_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                age_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rs1_q[i]     <= '0;
                rs2_q[i]     <= '0;
                payload_q[i] <= '0;
                age_q[i]     <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            rdy1_q    <= rdy1_d;
            rdy2_q    <= rdy2_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            payload_q <= payload_d;
            age_q     <= age_d;
        end
    end
endmodule

// File: tb/tb_mono_rs.sv
// Bench for mono_rs: directed vector table, hand sequences and a queue-based reference model.
module tb_mono_rs;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned PRF_IDX_W = 6;
    localparam int unsigned PAYLOAD_W = 64;
    localparam int unsigned CDB_WIDTH = 2;
`ifdef MONO_RS_ISSUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct packed {
        logic        dv;
        logic [63:0] pl;
        logic [5:0]  rs1;
        logic [5:0]  rs2;
        logic        r1;
        logic        r2;
        logic [1:0]  cv;
        logic [5:0]  ct0;
        logic [5:0]  ct1;
        logic        ir;
        logic        fl;
    } stim_t;

    typedef struct packed {
        stim_t       s;
        logic        eiv;
        logic [63:0] epl;
        logic [3:0]  eocc;
        logic        edr;
    } vec_t;

    typedef struct {
        logic [63:0] pl;
        logic [5:0]  rs1;
        logic [5:0]  rs2;
        logic        r1;
        logic        r2;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mono_rs_if #(
        .DEPTH(DEPTH), .PRF_IDX_W(PRF_IDX_W), .PAYLOAD_W(PAYLOAD_W), .CDB_WIDTH(CDB_WIDTH)
    ) rs_if ();

    mono_rs #(
        .DEPTH(DEPTH), .PRF_IDX_W(PRF_IDX_W), .PAYLOAD_W(PAYLOAD_W), .CDB_WIDTH(CDB_WIDTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rs_if (rs_if)
    );

    ent_t mq[$];  // stored uops, oldest first
    int   n_chk;
    int   n_pass;

    function automatic stim_t st(input int dv, pl, rs1, rs2, r1, r2, cv, ct0, ct1, ir, fl);
        stim_t s;
        s.dv  = 1'(dv);
        s.pl  = 64'(pl);
        s.rs1 = 6'(rs1);
        s.rs2 = 6'(rs2);
        s.r1  = 1'(r1);
        s.r2  = 1'(r2);
        s.cv  = 2'(cv);
        s.ct0 = 6'(ct0);
        s.ct1 = 6'(ct1);
        s.ir  = 1'(ir);
        s.fl  = 1'(fl);
        return s;
    endfunction

    function automatic vec_t vv(input stim_t s, input int eiv, epl, eocc, edr);
        vec_t v;
        v.s    = s;
        v.eiv  = 1'(eiv);
        v.epl  = 64'(epl);
        v.eocc = 4'(eocc);
        v.edr  = 1'(edr);
        return v;
    endfunction

    function automatic logic hit(input logic [5:0] tag, input stim_t s);
        return (s.cv[0] && (s.ct0 == tag)) || (s.cv[1] && (s.ct1 == tag));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input stim_t s);
        rs_if.ds_valid   = s.dv;
        rs_if.ds_payload = s.pl;
        rs_if.ds_rs1     = s.rs1;
        rs_if.ds_rs2     = s.rs2;
        rs_if.ds_rs1_rdy = s.r1;
        rs_if.ds_rs2_rdy = s.r2;
        rs_if.cdb_valid  = s.cv;
        rs_if.cdb_tag    = {s.ct1, s.ct0};
        rs_if.iss_ready  = s.ir;
        rs_if.flush      = s.fl;
    endtask

    // Applies one cycle of stimulus, checks outputs against the model mid-cycle, advances model.
    task automatic step(input stim_t s, input string tag, output logic oiv,
                        output logic [63:0] opl, output logic [3:0] oocc, output logic odr);
        ent_t        e;
        int          c;
        logic        eiv, byp, in1, in2, edr;
        logic [63:0] epl;
        logic [5:0]  e1, e2;
        drive(s);
        @(negedge clk);
        oiv  = rs_if.iss_valid;
        opl  = rs_if.iss_payload;
        oocc = rs_if.occupancy;
        odr  = rs_if.ds_ready;

        edr = (mq.size() < DEPTH);
        c = -1;
        foreach (mq[i]) if (c < 0 && mq[i].r1 && mq[i].r2) c = i;
        in1 = s.r1 || (s.rs1 == 6'd0) || hit(s.rs1, s);
        in2 = s.r2 || (s.rs2 == 6'd0) || hit(s.rs2, s);
        eiv = 1'b0; byp = 1'b0; epl = '0; e1 = '0; e2 = '0;
        if (!s.fl) begin
            if (c >= 0) begin
                eiv = 1'b1; epl = mq[c].pl; e1 = mq[c].rs1; e2 = mq[c].rs2;
            end else if (BYPASS && s.dv && edr && in1 && in2) begin
                eiv = 1'b1; byp = 1'b1; epl = s.pl; e1 = s.rs1; e2 = s.rs2;
            end
        end
        chk({tag, ".occ"}, 64'(oocc), 64'(mq.size()));
        chk({tag, ".ds_ready"}, 64'(odr), 64'(edr));
        chk({tag, ".iss_valid"}, 64'(oiv), 64'(eiv));
        chk({tag, ".iss_payload"}, opl, epl);
        chk({tag, ".iss_rs1"}, 64'(rs_if.iss_rs1), 64'(e1));
        chk({tag, ".iss_rs2"}, 64'(rs_if.iss_rs2), 64'(e2));

        if (s.fl) begin
            mq.delete();
        end else begin
            if (eiv && s.ir && !byp) mq.delete(c);
            foreach (mq[i]) begin
                e = mq[i];
                if (hit(e.rs1, s)) e.r1 = 1'b1;
                if (hit(e.rs2, s)) e.r2 = 1'b1;
                mq[i] = e;
            end
            if (s.dv && edr && !(byp && s.ir)) begin
                e.pl = s.pl; e.rs1 = s.rs1; e.rs2 = s.rs2; e.r1 = in1; e.r2 = in2;
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    vec_t        tbl[20];
    logic        oiv, odr;
    logic [63:0] opl;
    logic [3:0]  oocc;
    stim_t       s;

    initial begin
        n_chk = 0;
        n_pass = 0;
        //           dv  pl    rs1 rs2 r1 r2 cv ct0 ct1 ir fl   iv  pl    occ dr
        tbl[0]  = vv(st(0, 0,    0,  0,  0, 0, 0, 0,  0,  0, 0), 0, 0,    0, 1);
        tbl[1]  = vv(st(1, 'hA5, 3,  5,  1, 1, 0, 0,  0,  1, 0), 0, 0,    0, 1);
        tbl[2]  = vv(st(0, 0,    0,  0,  0, 0, 0, 0,  0,  1, 0), 1, 'hA5, 1, 1);
        tbl[3]  = vv(st(0, 0,    0,  0,  0, 0, 0, 0,  0,  1, 0), 0, 0,    0, 1);
        tbl[4]  = vv(st(1, 'h0A, 7,  0,  0, 0, 0, 0,  0,  1, 0), 0, 0,    0, 1);
        tbl[5]  = vv(st(1, 'h0B, 1,  2,  1, 1, 0, 0,  0,  1, 0), 0, 0,    1, 1);
        tbl[6]  = vv(st(0, 0,    0,  0,  0, 0, 0, 0,  0,  1, 0), 1, 'h0B, 2, 1);
        tbl[7]  = vv(st(0, 0,    0,  0,  0, 0, 1, 7,  0,  1, 0), 0, 0,    1, 1);
        tbl[8]  = vv(st(0, 0,    0,  0,  0, 0, 0, 0,  0,  1, 0), 1, 'h0A, 1, 1);
        tbl[9]  = vv(st(0, 0,    0,  0,  0, 0, 0, 0,  0,  1, 0), 0, 0,    0, 1);
        tbl[10] = vv(st(1, 'h0C, 4,  9,  1, 0, 2, 0,  9,  1, 0), 0, 0,    0, 1);
        tbl[11] = vv(st(0, 0,    0,  0,  0, 0, 0, 0,  0,  1, 0), 1, 'h0C, 1, 1);
        tbl[12] = vv(st(0, 0,    0,  0,  0, 0, 0, 0,  0,  1, 0), 0, 0,    0, 1);
        tbl[13] = vv(st(1, 'h11, 20, 0,  0, 0, 0, 0,  0,  0, 0), 0, 0,    0, 1);
        tbl[14] = vv(st(1, 'h12, 20, 0,  0, 0, 0, 0,  0,  0, 0), 0, 0,    1, 1);
        tbl[15] = vv(st(1, 'h13, 1,  2,  1, 1, 0, 0,  0,  0, 0), 0, 0,    2, 1);
        tbl[16] = vv(st(1, 'h14, 1,  2,  1, 1, 0, 0,  0,  0, 0), 1, 'h13, 3, 1);
        tbl[17] = vv(st(1, 'h15, 1,  2,  1, 1, 0, 0,  0,  1, 1), 0, 0,    4, 1);
        tbl[18] = vv(st(0, 0,    0,  0,  0, 0, 0, 0,  0,  0, 0), 0, 0,    0, 1);
        tbl[19] = vv(st(0, 0,    0,  0,  0, 0, 0, 0,  0,  1, 0), 0, 0,    0, 1);

        rst = 1'b1;
        drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int k = 0; k < 20; k++) begin
            step(tbl[k].s, $sformatf("row%0d", k), oiv, opl, oocc, odr);
`ifndef MONO_RS_ISSUE_BYPASS_EN
            chk($sformatf("row%0d.tbl_iv", k), 64'(oiv), 64'(tbl[k].eiv));
            chk($sformatf("row%0d.tbl_pl", k), opl, tbl[k].epl);
            chk($sformatf("row%0d.tbl_occ", k), 64'(oocc), 64'(tbl[k].eocc));
            chk($sformatf("row%0d.tbl_dr", k), 64'(odr), 64'(tbl[k].edr));
`endif
        end

        // Fill to DEPTH, check back-pressure and release one cycle after issue.
        for (int i = 0; i < DEPTH; i++) begin
            step(st(1, 'h100 + i, 1, 2, 1, 1, 0, 0, 0, 0, 0), "fill", oiv, opl, oocc, odr);
        end
        step(st(1, 'h1FF, 1, 2, 1, 1, 0, 0, 0, 0, 0), "full", oiv, opl, oocc, odr);
        chk("full.occ8", 64'(oocc), 64'd8);
        chk("full.ds_ready0", 64'(odr), 64'd0);
        chk("full.oldest", opl, 64'h100);
        step(st(1, 'h1FE, 1, 2, 1, 1, 0, 0, 0, 1, 0), "full_iss", oiv, opl, oocc, odr);
        chk("full_iss.ds_ready0", 64'(odr), 64'd0);
        chk("full_iss.pl", opl, 64'h100);
        step(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "after_iss", oiv, opl, oocc, odr);
        chk("after_iss.ds_ready1", 64'(odr), 64'd1);
        chk("after_iss.occ7", 64'(oocc), 64'd7);
        for (int i = 0; i < DEPTH; i++) begin
            step(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "drain", oiv, opl, oocc, odr);
        end

        // Age order across recycled, non-contiguous slots.
        for (int i = 0; i < 4; i++) begin
            step(st(1, 'h200 + i, 30 + i, 0, 0, 0, 0, 0, 0, 0, 0), "park", oiv, opl, oocc, odr);
        end
        step(st(0, 0, 0, 0, 0, 0, 3, 31, 33, 0, 0), "wake13", oiv, opl, oocc, odr);
        step(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "free1", oiv, opl, oocc, odr);
        chk("free1.pl", opl, 64'h201);
        step(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "free3", oiv, opl, oocc, odr);
        chk("free3.pl", opl, 64'h203);
        step(st(1, 'h58, 1, 2, 1, 1, 0, 0, 0, 0, 0), "disp_x", oiv, opl, oocc, odr);
        step(st(1, 'h59, 1, 2, 1, 1, 0, 0, 0, 0, 0), "disp_y", oiv, opl, oocc, odr);
        step(st(1, 'h5A, 1, 2, 1, 1, 0, 0, 0, 0, 0), "disp_z", oiv, opl, oocc, odr);
        for (int i = 0; i < 3; i++) begin
            step(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "xyz", oiv, opl, oocc, odr);
            chk($sformatf("xyz%0d.pl", i), opl, 64'h58 + 64'(i));
        end
        step(st(0, 0, 0, 0, 0, 0, 3, 30, 32, 1, 0), "wake02", oiv, opl, oocc, odr);
        chk("wake02.iv0", 64'(oiv), 64'd0);
        step(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "p0", oiv, opl, oocc, odr);
        chk("p0.pl", opl, 64'h200);
        step(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "p2", oiv, opl, oocc, odr);
        chk("p2.pl", opl, 64'h202);
        step(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "empty", oiv, opl, oocc, odr);

        for (int n = 0; n < 1500; n++) begin
            s = st(int'($urandom_range(0, 9) < 6), int'($urandom),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 9) < 3), int'($urandom_range(0, 9) < 3),
                   int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 9) < 6), int'($urandom_range(0, 49) == 0));
            step(s, "rnd", oiv, opl, oocc, odr);
        end

        // Asynchronous reset in the middle of a cycle with entries held.
        step(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "pre_rst_flush", oiv, opl, oocc, odr);
        for (int i = 0; i < 3; i++) begin
            step(st(1, 'h300 + i, 40, 0, 0, 0, 0, 0, 0, 0, 0), "pre_rst", oiv, opl, oocc, odr);
        end
        drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        #2;
        chk("mid_rst.occ", 64'(rs_if.occupancy), 64'd0);
        chk("mid_rst.iss_valid", 64'(rs_if.iss_valid), 64'd0);
        chk("mid_rst.ds_ready", 64'(rs_if.ds_ready), 64'd1);
        mq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "post_rst", oiv, opl, oocc, odr);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
